// File: rtl/axi_master_bridge.sv
// Bridges a simple request/response port onto an AXI4 master interface.
// One transaction in flight: INCR read bursts up to MAX_LEN+1 beats, single-beat writes.
module axi_master_bridge #(
  parameter logic [3:0] AXI_ID  = 4'd0,
  parameter logic [7:0] MAX_LEN = 8'd7
) (
  input  logic        clock,
  input  logic        reset,
  // simple request/response port
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_last,
  output logic        resp_err,
  // AXI AR
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arid,
  output logic        arvalid,
  input  logic        arready,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  // AXI R
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid,
  input  logic        rvalid,
  output logic        rready,
  // AXI AW
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [3:0]  awid,
  output logic        awvalid,
  input  logic        awready,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  // AXI W
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic [3:0]  wid,
  output logic        wvalid,
  input  logic        wready,
  // AXI B
  input  logic [1:0]  bresp,
  input  logic [3:0]  bid,
  input  logic        bvalid,
  output logic        bready
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 8;
  localparam int unsigned LW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [LW-1:0]  len_q, len_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [SW-1:0]  wstrb_q, wstrb_d;
  logic [LW-1:0]  cnt_q, cnt_d;
  logic           aw_done_q, aw_done_d;
  logic           w_done_q, w_done_d;

  logic           cnt_at_len;
  logic           rd_end;
  logic           aw_hs, w_hs;

  // Response IDs are not checked by this bridge.
  logic unused_ids;
  assign unused_ids = ^{rid, bid};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Address/data channel fields come straight from the latched request.
  always_comb begin
    araddr  = (len_q != '0) ? {addr_q[AW-1:3], 3'b000} : addr_q;
    arlen   = len_q;
    arsize  = 3'd3;
    arburst = 2'b01;
    arid    = AXI_ID;
    arlock  = '0;
    arcache = '0;
    arprot  = '0;
    awaddr  = addr_q;
    awlen   = '0;
    awsize  = 3'd3;
    awburst = 2'b01;
    awid    = AXI_ID;
    awlock  = '0;
    awcache = '0;
    awprot  = '0;
    wdata   = wdata_q;
    wstrb   = wstrb_q;
    wlast   = 1'b1;
    wid     = AXI_ID;
  end

  assign cnt_at_len = (cnt_q == len_q);
  assign rd_end     = rlast | cnt_at_len;
  assign aw_hs      = awvalid & awready;
  assign w_hs       = wvalid & wready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    cnt_d      = cnt_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_last  = 1'b0;
    resp_err   = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (req_wen) begin
            len_d   = '0;
            state_d = S_WR_REQ;
          end else begin
            len_d   = (req_len > MAX_LEN) ? MAX_LEN : req_len;
            state_d = S_RD_ADDR;
          end
        end
      end

      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RD_DATA;
      end

      // Zero-latency pass-through; the burst ends on rlast or on the expected final beat.
      S_RD_DATA: begin
        rready     = resp_ready;
        resp_valid = rvalid;
        resp_rdata = rdata;
        resp_last  = rd_end;
        resp_err   = (rresp != 2'b00) | (rlast != cnt_at_len);
        if (rvalid && resp_ready) begin
          cnt_d = cnt_q + LW'(1);
          if (rd_end) state_d = S_IDLE;
        end
      end

      // AW and W complete independently, possibly in the same cycle.
      S_WR_REQ: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = S_WR_RESP;
      end

      S_WR_RESP: begin
        bready     = resp_ready;
        resp_valid = bvalid;
        resp_last  = 1'b1;
        resp_err   = (bresp != 2'b00);
        if (bvalid && resp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed bench for axi_master_bridge: the bench plays the AXI slave and the requester.
module tb_axi_master_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_last, resp_err;
  logic [63:0] resp_rdata;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic [3:0]  arid, awid, wid, arcache, awcache, rid, bid;
  logic        arvalid, arready, awvalid, awready;
  logic [63:0] rdata, wdata;
  logic [1:0]  rresp, bresp;
  logic        rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;
  logic [7:0]  wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  axi_master_bridge dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_last(resp_last), .resp_err(resp_err),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
    .arvalid(arvalid), .arready(arready), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
    .awvalid(awvalid), .awready(awready), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wid(wid), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready)
  );

  // Advance to just after the next rising edge; inputs are then driven and outputs checked.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_wen = 0; req_addr = '0; req_len = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 0; arready = 0; awready = 0; wready = 0;
    rdata = '0; rresp = '0; rlast = 0; rid = '0; rvalid = 0;
    bresp = '0; bid = '0; bvalid = 0;
  endtask

  task automatic issue_read(input logic [31:0] a, input logic [7:0] l);
    req_valid = 1; req_wen = 0; req_addr = a; req_len = l;
    cyc();
    req_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
      errors++; $display("FAIL reset_axi_valids got %b want 00000", {arvalid, awvalid, wvalid, rready, bready});
    end
    checks++;
    if ({resp_valid, resp_last, resp_err} !== 3'b0 || resp_rdata !== 64'h0) begin
      errors++; $display("FAIL reset_resp got v%b l%b e%b d%h want all 0", resp_valid, resp_last, resp_err, resp_rdata);
    end
    checks++;
    if ({arlock, arcache, arprot, awlock, awcache, awprot} !== 18'h0 || arid !== 4'h0 || wid !== 4'h0) begin
      errors++; $display("FAIL const_sidebands got nonzero want 0");
    end
  endtask

  task automatic test_read_single();
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0000; req_len = 8'd0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rd1_accept got %b want 1", req_ready); end
    cyc();
    req_valid = 0;
    #1;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0000 || arlen !== 8'd0 || arsize !== 3'd3 || arburst !== 2'b01) begin
      errors++; $display("FAIL rd1_ar got v%b a%h l%0d s%0d b%0d want 1 80000000 0 3 1", arvalid, araddr, arlen, arsize, arburst);
    end
    cyc();
    cyc();
    arready = 1;
    #1;
    checks++;
    if (arvalid !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL rd1_ar_hold got arvalid %b req_ready %b want 1 0", arvalid, req_ready);
    end
    cyc();
    arready = 0;
    rvalid = 1; rdata = 64'h1122_3344_5566_7788; rlast = 1; rresp = 0; resp_ready = 1;
    #1;
    checks++;
    if (arvalid !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 64'h1122_3344_5566_7788 ||
        resp_last !== 1'b1 || resp_err !== 1'b0 || rready !== 1'b1) begin
      errors++; $display("FAIL rd1_beat got arv%b v%b d%h l%b e%b rr%b want 0 1 1122334455667788 1 0 1",
                         arvalid, resp_valid, resp_rdata, resp_last, resp_err, rready);
    end
    cyc();
    rvalid = 0; rlast = 0; resp_ready = 0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rd1_done got req_ready %b resp_valid %b want 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_read_burst();
    logic [63:0] exp_d [4];
    logic [63:0] got_d [$];
    logic [3:0]  got_last;
    int stall;
    for (int i = 0; i < 4; i++) exp_d[i] = 64'hB000_0000_0000_0000 + 64'(i * 17 + 1);
    got_last = '0;
    issue_read(32'h8000_0014, 8'd3);
    #1;
    checks++;
    if (araddr !== 32'h8000_0010 || arlen !== 8'd3) begin
      errors++; $display("FAIL burst_ar got a%h l%0d want 80000010 3", araddr, arlen);
    end
    arready = 1;
    cyc();
    arready = 0;
    stall = 0;
    for (int b = 0; b < 4; b++) begin
      rvalid = 1; rdata = exp_d[b]; rlast = (b == 3); rresp = 0;
      resp_ready = !(b == 2 && stall < 2);
      #1;
      if (b == 2 && stall < 2) begin
        checks++;
        if (rready !== 1'b0 || resp_valid !== 1'b1) begin
          errors++; $display("FAIL burst_stall got rready %b resp_valid %b want 0 1", rready, resp_valid);
        end
        stall++;
        b--;
      end else begin
        if (resp_valid === 1'b1 && rready === 1'b1) begin
          got_d.push_back(resp_rdata);
          got_last[got_d.size()-1] = resp_last;
        end
        if (resp_err !== 1'b0) begin
          checks++; errors++; $display("FAIL burst_err beat %0d got %b want 0", b, resp_err);
        end
      end
      cyc();
    end
    rvalid = 0; rlast = 0; resp_ready = 0;
    #1;
    checks++;
    if (got_d.size() != 4) begin
      errors++; $display("FAIL burst_count got %0d want 4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_d[i] !== exp_d[i]) begin
          errors++; $display("FAIL burst_data beat %0d got %h want %h", i, got_d[i], exp_d[i]);
        end
      end
    end
    checks++;
    if (got_last !== 4'b1000) begin errors++; $display("FAIL burst_last got %b want 1000", got_last); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL burst_idle got %b want 1", req_ready); end
  endtask

  task automatic test_write();
    req_valid = 1; req_wen = 1; req_addr = 32'h8000_0008;
    req_wdata = 64'h0000_0000_DEAD_BEEF; req_wstrb = 8'h0F; req_len = 8'd5;
    cyc();
    req_valid = 0; req_wen = 0;
    #1;
    checks++;
    if (awvalid !== 1 || wvalid !== 1 || awaddr !== 32'h8000_0008 || awlen !== 8'd0 || awsize !== 3'd3 ||
        awburst !== 2'b01 || wdata !== 64'hDEAD_BEEF || wstrb !== 8'h0F || wlast !== 1) begin
      errors++; $display("FAIL wr_req got awv%b wv%b a%h l%0d s%0d b%0d d%h st%h wl%b", awvalid, wvalid,
                         awaddr, awlen, awsize, awburst, wdata, wstrb, wlast);
    end
    awready = 1;
    cyc();
    awready = 0;
    #1;
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL wr_aw_only got awv%b wv%b rq%b want 0 1 0", awvalid, wvalid, req_ready);
    end
    wready = 1;
    cyc();
    wready = 0;
    bvalid = 1; bresp = 0; resp_ready = 1;
    #1;
    checks++;
    if (awvalid !== 0 || wvalid !== 0 || resp_valid !== 1 || resp_last !== 1 || resp_err !== 0 ||
        resp_rdata !== 64'h0 || bready !== 1) begin
      errors++; $display("FAIL wr_resp got awv%b wv%b v%b l%b e%b d%h br%b want 0 0 1 1 0 0 1",
                         awvalid, wvalid, resp_valid, resp_last, resp_err, resp_rdata, bready);
    end
    cyc();
    bvalid = 0; resp_ready = 0;
    // Both handshakes in the entry cycle, then an error response.
    req_valid = 1; req_wen = 1; req_addr = 32'h8000_0020; req_wdata = 64'h55; req_wstrb = 8'hFF;
    cyc();
    req_valid = 0; req_wen = 0;
    awready = 1; wready = 1;
    cyc();
    awready = 0; wready = 0;
    bvalid = 1; bresp = 2'b10; resp_ready = 1;
    #1;
    checks++;
    if (awvalid !== 0 || wvalid !== 0 || resp_valid !== 1 || resp_err !== 1) begin
      errors++; $display("FAIL wr_both_err got awv%b wv%b v%b e%b want 0 0 1 1", awvalid, wvalid, resp_valid, resp_err);
    end
    cyc();
    bvalid = 0; bresp = 0; resp_ready = 0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_idle got %b want 1", req_ready); end
  endtask

  task automatic test_errors();
    issue_read(32'h8000_0100, 8'd3);
    arready = 1;
    cyc();
    arready = 0;
    rvalid = 1; rdata = 64'h1; rlast = 0; rresp = 0; resp_ready = 1;
    #1;
    checks++;
    if (resp_err !== 0 || resp_last !== 0) begin
      errors++; $display("FAIL early_b0 got e%b l%b want 0 0", resp_err, resp_last);
    end
    cyc();
    rdata = 64'h2; rlast = 1;
    #1;
    checks++;
    if (resp_err !== 1 || resp_last !== 1 || resp_valid !== 1) begin
      errors++; $display("FAIL early_rlast got e%b l%b v%b want 1 1 1", resp_err, resp_last, resp_valid);
    end
    cyc();
    rvalid = 0; rlast = 0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL early_idle got %b want 1", req_ready); end
    issue_read(32'h8000_0200, 8'd0);
    arready = 1;
    cyc();
    arready = 0;
    rvalid = 1; rlast = 1; rresp = 2'b10; rdata = 64'h3;
    #1;
    checks++;
    if (resp_err !== 1 || resp_last !== 1) begin
      errors++; $display("FAIL rresp_err got e%b l%b want 1 1", resp_err, resp_last);
    end
    cyc();
    rvalid = 0; rlast = 0; rresp = 0; resp_ready = 0;
  endtask

  task automatic test_mid_reset();
    issue_read(32'h8000_0300, 8'd20);
    #1;
    checks++;
    if (arlen !== 8'd7 || araddr !== 32'h8000_0300) begin
      errors++; $display("FAIL clamp_len got l%0d a%h want 7 80000300", arlen, araddr);
    end
    arready = 1;
    cyc();
    arready = 0;
    rvalid = 1; rdata = 64'h9; rlast = 0; resp_ready = 1;
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    #1;
    checks++;
    if (arvalid !== 0 || rready !== 0 || resp_valid !== 0 || req_ready !== 1) begin
      errors++; $display("FAIL mid_reset got arv%b rr%b v%b rq%b want 0 0 0 1", arvalid, rready, resp_valid, req_ready);
    end
    rvalid = 0; resp_ready = 0;
  endtask

  task automatic test_back_to_back();
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0044; req_len = 8'd0;
    cyc();
    #1;
    checks++;
    if (req_ready !== 0 || arvalid !== 1 || araddr !== 32'h8000_0044) begin
      errors++; $display("FAIL b2b_rdaddr got rq%b arv%b a%h want 0 1 80000044", req_ready, arvalid, araddr);
    end
    arready = 1;
    cyc();
    arready = 0;
    rvalid = 1; rlast = 1; rdata = 64'h44; resp_ready = 1;
    #1;
    checks++;
    if (req_ready !== 0 || resp_valid !== 1) begin
      errors++; $display("FAIL b2b_final got rq%b v%b want 0 1", req_ready, resp_valid);
    end
    cyc();
    rvalid = 0; rlast = 0; resp_ready = 0;
    #1;
    checks++;
    if (req_ready !== 1 || arvalid !== 0) begin
      errors++; $display("FAIL b2b_idle got rq%b arv%b want 1 0", req_ready, arvalid);
    end
    cyc();
    req_valid = 0;
    #1;
    checks++;
    if (arvalid !== 1 || req_ready !== 0) begin
      errors++; $display("FAIL b2b_second got arv%b rq%b want 1 0", arvalid, req_ready);
    end
    reset = 1;
    cyc();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_read_single();
    test_read_burst();
    test_write();
    test_errors();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
